xor_unmask_rx: RTL and testbench
================================

# xor_unmask_rx

Serial receiver that undoes the masking performed by the combinational encoder `y = ~c & (a ^ b)`. Each input slot carries an encoded bit `y_in`, the key bit `b_in` used to encode it and a blank flag `c_in`. Non-blank slots are decoded as `a = y_in ^ b_in` and packed LSB-first into WIDTH-bit words. Words are presented to the downstream consumer through a valid/ready holding register. The block sits at the receive end of the encoder's serial link.

## Interface
- WIDTH, 8: data bits per word, minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  slot present this cycle.
- y_in  in  1  encoded bit.
- b_in  in  1  key bit for this slot.
- c_in  in  1  blank flag; 1 = slot carries no data.
- out_data  out  WIDTH  decoded word, bit 0 = first received bit.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overrun  out  1  sticky: a completed word was dropped.
- blank_err  out  1  sticky: a blank slot arrived with y_in = 1.
- parity_err  out  1  see Configuration.

Clock and reset are fixed: one clock, asynchronous active-low reset.

## Operation
- **Reset values.** Reset forces all outputs and all state to 0: shift register, bit counter, out_data, out_valid, overrun, blank_err, parity_err. The state machine enters IDLE.
- **State machine.**
  - IDLE: bit counter is 0. A data slot moves the machine to SHIFT.
  - SHIFT: each data slot increments the counter. The slot that makes the count equal FRAME (WIDTH, or WIDTH+1 with parity) completes the word, and the machine returns to IDLE.
- **Data slot** (in_valid=1, c_in=0):
  - decoded bit = y_in ^ b_in;
  - shift register updates as `sr <= {bit, sr[FRAME-1:1]}`.
- **Blank slot** (in_valid=1, c_in=1):
  - slot is ignored; counter and shift register are unchanged;
  - if y_in=1, blank_err is set.
- **in_valid=0:** no state change.
- **Word completion:**
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle, the new word loads into out_data and out_valid is 1.
  - Otherwise the new word is dropped, out_data keeps the old word, and overrun is set.
  - Either way the counter wraps to 0.
- **Consume:** out_valid && out_ready with no completion in that cycle clears out_valid. out_data keeps its last value.
- **Sticky flags:** overrun and blank_err clear only on reset.

## Timing
- Latency: out_valid and out_data update on the same clock edge that samples the final bit of a word. They are visible 0 cycles after that edge, i.e. no extra pipeline stage.
- Throughput: one bit per cycle. A back-to-back stream of words produces no overrun as long as out_ready is high in each completion cycle.
- out_data must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-word discards the partial word and any held word. Reception restarts counting from the first data slot after rst_n deasserts.
- All inputs are sampled on the rising edge of clk. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `XOR_RX_PARITY_EN`.
- **Defined:**
  - FRAME = WIDTH+1; the last data bit of each frame is an even-parity bit over the WIDTH data bits;
  - out_data carries only the WIDTH data bits;
  - parity_err is a registered flag loaded with each word that is accepted into out_data; it is 1 when the parity bit mismatches;
  - on a dropped word, parity_err is unchanged.
- **Undefined:** FRAME = WIDTH, and parity_err is tied to 0.

## Test plan
- **Plain decode.** WIDTH=8, b_in=0, y bits of 0xA5 sent LSB-first over 8 consecutive slots with out_ready=1 -> out_data=0xA5 and out_valid=1 at the 8th edge.
- **Keyed decode with blanks.** b_in=1 on all slots, y bits of 0x5A, with a blank slot (c_in=1, y_in=0) after every data slot -> out_data=0xA5 after 16 slots; blank_err=0.
- **Backpressure / overrun.** out_ready=0; send 0x11 then 0x22 -> out_data stays 0x11 and overrun=1. Then out_ready=1 for one cycle -> out_valid=0 and overrun stays 1.
- **Simultaneous consume and complete.** out_valid=1 holding 0x11, with out_ready=1 in the cycle the last bit of 0x22 arrives -> out_data=0x22, out_valid=1, overrun=0.
- **Blank error / reset mid-word.** Blank slot with y_in=1 -> blank_err=1. Then 4 data bits, rst_n pulsed low, then 0xC3 sent -> out_data=0xC3 and all flags 0.
- **Parity** (`XOR_RX_PARITY_EN`). 0xA5 plus parity bit 0 -> parity_err=0. 0xA5 plus parity bit 1 -> parity_err=1 and out_data=0xA5.

Source files
------------

// File: rtl/xor_unmask_rx_if.sv
// +--------------------------------------------------------------------------+
// | xor_unmask_rx_if : slot-in / word-out bundle for xor_unmask_rx. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface xor_unmask_rx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             y_in;
    logic             b_in;
    logic             c_in;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             blank_err;
    logic             parity_err;

    modport master (
        output in_valid, y_in, b_in, c_in, out_ready,
        input  out_data, out_valid, overrun, blank_err, parity_err
    );

    modport slave (
        input  in_valid, y_in, b_in, c_in, out_ready,
        output out_data, out_valid, overrun, blank_err, parity_err
    );
endinterface

`default_nettype wire

// File: rtl/xor_unmask_rx.sv
// +--------------------------------------------------------------------------+
// | xor_unmask_rx : decodes y^b slots LSB-first into WIDTH-bit words. Rev 1.0|
// | Optional macro XOR_RX_PARITY_EN adds a trailing even-parity bit/frame.   |
// +--------------------------------------------------------------------------+
`default_nettype none

module xor_unmask_rx #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    xor_unmask_rx_if.slave bus
);
`ifdef XOR_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [FRAME-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             blank_err;

    logic             data_slot;
    logic             bit_dec;
    logic [FRAME-1:0] sr_next;
    logic             last_bit;
    logic             accept;

    assign data_slot = bus.in_valid && !bus.c_in;
    assign bit_dec   = bus.y_in ^ bus.b_in;
    assign sr_next   = {bit_dec, sr[FRAME-1:1]};
    assign last_bit  = data_slot && (cnt == CNT_W'(FRAME - 1));
    // A held word may be replaced in the same cycle it is being consumed.
    assign accept    = !out_valid || bus.out_ready;

`ifdef XOR_RX_PARITY_EN
    logic parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (last_bit && accept) begin
            parity_err <= ^sr_next;
        end
    end

    assign bus.parity_err = parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            blank_err <= 1'b0;
        end else begin
            if (data_slot) begin
                sr <= sr_next;
                if (last_bit) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE:    cnt <= CNT_W'(1);
                        default: cnt <= cnt + CNT_W'(1);
                    endcase
                    state <= SHIFT;
                end
            end

            if (bus.in_valid && bus.c_in && bus.y_in) begin
                blank_err <= 1'b1;
            end

            if (last_bit) begin
                if (accept) begin
                    out_data  <= sr_next[WIDTH-1:0];
                    out_valid <= 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.overrun   = overrun;
    assign bus.blank_err = blank_err;

endmodule

`default_nettype wire

// File: tb/tb_xor_unmask_rx.sv
// +--------------------------------------------------------------------------+
// | tb_xor_unmask_rx : directed self-checking bench for xor_unmask_rx. Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_xor_unmask_rx;
    localparam int W = 8;
`ifdef XOR_RX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xor_unmask_rx_if #(.WIDTH(W)) bus ();

    xor_unmask_rx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One slot per clock; returns 1 time unit after the sampling edge.
    task automatic send_slot(input logic y, input logic b, input logic c);
        bus.in_valid = 1'b1;
        bus.y_in     = y;
        bus.b_in     = b;
        bus.c_in     = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame of word a under key k; ready_last raises out_ready just
    // before the final slot, bad_par flips the parity bit when it exists.
    task automatic send_word(input logic [W-1:0] a, input logic k,
                             input logic ready_last, input logic bad_par);
        logic [W:0] f;
        f = {(^a) ^ bad_par, a};
        for (int i = 0; i < FRAME; i++) begin
            if (ready_last && i == FRAME - 1) bus.out_ready = 1'b1;
            send_slot(f[i] ^ k, k, 1'b0);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.y_in      = 1'b0;
        bus.b_in      = 1'b0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        checks++; if (bus.blank_err !== 1'b0) begin errors++; $display("FAIL reset_blank got %b want 0", bus.blank_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", bus.parity_err); end
    endtask

    task automatic test_plain_decode();
        logic [W:0] f;
        do_reset();
        bus.out_ready = 1'b1;
        f = {^8'hA5, 8'hA5};
        for (int i = 0; i < FRAME - 1; i++) send_slot(f[i], 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL plain_early_valid got %b want 0", bus.out_valid); end
        send_slot(f[FRAME-1], 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL plain_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL plain_data got %h want a5", bus.out_data); end
    endtask

    task automatic test_keyed_blanks();
        logic [W:0] f;
        do_reset();
        bus.out_ready = 1'b1;
        // a = 0xA5 encoded with key 1 gives y = 0x5A on the data bits
        f = {^8'hA5, 8'hA5};
        for (int i = 0; i < FRAME; i++) begin
            send_slot(f[i] ^ 1'b1, 1'b1, 1'b0);
            if (i == FRAME - 1) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL keyed_valid got %b want 1", bus.out_valid); end
            end
            send_slot(1'b0, 1'b1, 1'b1);
        end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL keyed_data got %h want a5", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL keyed_consumed got %b want 0", bus.out_valid); end
        checks++; if (bus.blank_err !== 1'b0) begin errors++; $display("FAIL keyed_blank got %b want 0", bus.blank_err); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b want 1", bus.out_valid); end
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h want 11", bus.out_data); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
        bus.out_ready = 1'b1;
        idle_cycle();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b want 0", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL ovr_keep got %h want 11", bus.out_data); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] f;
        do_reset();
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        f = {^8'h22, 8'h22};
        for (int i = 0; i < 4; i++) send_slot(f[i], 1'b0, 1'b0);
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL b2b_hold got %h want 11", bus.out_data); end
        for (int i = 4; i < FRAME - 1; i++) send_slot(f[i], 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        send_slot(f[FRAME-1], 1'b0, 1'b0);
        checks++; if (bus.out_data !== 8'h22) begin errors++; $display("FAIL b2b_data got %h want 22", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
        // ready held high keeps a continuous stream free of overrun
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.out_data !== 8'h3C) begin errors++; $display("FAIL b2b_stream got %h want 3c", bus.out_data); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_stream_ovr got %b want 0", bus.overrun); end
    endtask

    task automatic test_blank_err_reset();
        do_reset();
        send_slot(1'b1, 1'b0, 1'b1);
        checks++; if (bus.blank_err !== 1'b1) begin errors++; $display("FAIL blank_set got %b want 1", bus.blank_err); end
        for (int i = 0; i < 4; i++) send_slot(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.blank_err !== 1'b0) begin errors++; $display("FAIL async_reset got %b want 0", bus.blank_err); end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL restart_data got %h want c3", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b want 1", bus.out_valid); end
        checks++; if ({bus.overrun, bus.blank_err, bus.parity_err} !== 3'b000) begin
            errors++; $display("FAIL restart_flags got %b want 000", {bus.overrun, bus.blank_err, bus.parity_err});
        end
    endtask

`ifdef XOR_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        bus.out_ready = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL par_good got %b want 0", bus.parity_err); end
        send_word(8'hA5, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL par_bad got %b want 1", bus.parity_err); end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL par_data got %h want a5", bus.out_data); end
        send_word(8'h0F, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL par_reload got %b want 0", bus.parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_plain_decode();
        test_keyed_blanks();
        test_overrun();
        test_back_to_back();
        test_blank_err_reset();
`ifdef XOR_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
